// File: rtl/snake_pkg.sv
// Shared constants and types for the snake collision-scan slice.
// Holds the playfield bounds, the FSM state encoding and the length helper.
package snake_pkg;

    localparam int COORD_W = 20;
    localparam int LEN_W   = 6;

    localparam logic [COORD_W-1:0] X_MIN = 20'd143;
    localparam logic [COORD_W-1:0] X_MAX = 20'd784;
    localparam logic [COORD_W-1:0] Y_MIN = 20'd35;
    localparam logic [COORD_W-1:0] Y_MAX = 20'd514;

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALL = 2'd1,
        ST_SCAN = 2'd2,
        ST_FIN  = 2'd3
    } scanState_e;

    // A zero-length snake still has a head, so it is scanned as length one.
    function automatic logic [LEN_W-1:0] effLength(input logic [LEN_W-1:0] len);
        effLength = (len == {LEN_W{1'b0}}) ? LEN_ONE : len;
    endfunction

endpackage

// File: rtl/collision_scan_ctrl_if.sv
// Bundle between tick/movement logic, segment RAM and the collision sequencer.
interface collision_scan_ctrl_if;
    import snake_pkg::*;

    logic               start;
    logic [COORD_W-1:0] headX;
    logic [COORD_W-1:0] headY;
    logic [LEN_W-1:0]   length;
    logic               walls;
    logic               clearGame;
    logic               segRd;
    logic [LEN_W-1:0]   segAddr;
    logic [COORD_W-1:0] segX;
    logic [COORD_W-1:0] segY;
    logic               busy;
    logic               done;
    logic               gameOver;
    logic               hitWall;
    logic               hitBody;

    modport master (
        output start, headX, headY, length, walls, clearGame, segX, segY,
        input  segRd, segAddr, busy, done, gameOver, hitWall, hitBody
    );

    modport slave (
        input  start, headX, headY, length, walls, clearGame, segX, segY,
        output segRd, segAddr, busy, done, gameOver, hitWall, hitBody
    );

endinterface

// File: rtl/collision_scan_ctrl_bounds_check.sv
// Combinational playfield-wall test of the latched head position.
module coord_bounds_check
    import snake_pkg::*;
(
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               enable,
    output logic               hit
);

    // Bounds are inclusive-legal; anything strictly outside is a wall hit.
    always_comb begin
        hit = 1'b0;
        if (enable) begin
            hit = (x < X_MIN) || (x > X_MAX) || (y < Y_MIN) || (y > Y_MAX);
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/collision_scan_ctrl.sv
// Per-tick collision sequencer: wall check, then one body segment per clock,
// with sticky game-over and cause flags.
module collision_scan_ctrl
    import snake_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    collision_scan_ctrl_if.slave bus
);

    scanState_e         state_r;
    logic [COORD_W-1:0] hX_r;
    logic [COORD_W-1:0] hY_r;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   segAddr_r;
    logic               segRd_r;
    logic               busy_r;
    logic               done_r;
    logic               gameOver_r;
    logic               hitWall_r;
    logic               hitBody_r;

    logic               wallHit_s;
    logic               bodyHit_s;
    logic               lastSeg_s;
    logic               accept_s;

    coord_bounds_check uBounds (
        .x      (hX_r),
        .y      (hY_r),
        .enable (bus.walls),
        .hit    (wallHit_s)
    );

    // Segment compare against the RAM data for the address currently shown.
    always_comb begin
        bodyHit_s = (bus.segX == hX_r) && (bus.segY == hY_r);
        lastSeg_s = (segAddr_r == (len_r - LEN_ONE));
        accept_s  = (state_r == ST_IDLE) && bus.start && !gameOver_r;
    end

    // Sequencer state, address walk and sticky flags; a hit overrides clearGame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            hX_r       <= {COORD_W{1'b0}};
            hY_r       <= {COORD_W{1'b0}};
            len_r      <= LEN_ONE;
            segAddr_r  <= {LEN_W{1'b0}};
            segRd_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            gameOver_r <= 1'b0;
            hitWall_r  <= 1'b0;
            hitBody_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (bus.clearGame) begin
                gameOver_r <= 1'b0;
                hitWall_r  <= 1'b0;
                hitBody_r  <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        hX_r    <= bus.headX;
                        hY_r    <= bus.headY;
                        len_r   <= effLength(bus.length);
                        busy_r  <= 1'b1;
                        state_r <= ST_WALL;
                    end
                end
                ST_WALL: begin
                    if (wallHit_s || (len_r <= LEN_ONE)) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_FIN;
                        if (wallHit_s) begin
                            gameOver_r <= 1'b1;
                            hitWall_r  <= 1'b1;
                        end
                    end else begin
                        segRd_r   <= 1'b1;
                        segAddr_r <= LEN_ONE;
                        state_r   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (bodyHit_s || lastSeg_s) begin
                        segRd_r <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_FIN;
                        if (bodyHit_s) begin
                            gameOver_r <= 1'b1;
                            hitBody_r  <= 1'b1;
                        end
                    end else begin
                        segAddr_r <= segAddr_r + LEN_ONE;
                    end
                end
                ST_FIN: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.segRd    = segRd_r;
    assign bus.segAddr  = segAddr_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.gameOver = gameOver_r;
    assign bus.hitWall  = hitWall_r;
    assign bus.hitBody  = hitBody_r;

endmodule

// File: tb/tb_collision_scan_ctrl.sv
// Bench for collision_scan_ctrl: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_collision_scan_ctrl;
    import snake_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   nChecks = 0;
    int   nFails  = 0;

    collision_scan_ctrl_if busIf ();

    collision_scan_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busIf)
    );

    always #5 clk = ~clk;

    logic [COORD_W-1:0] memX [64];
    logic [COORD_W-1:0] memY [64];
    assign busIf.segX = memX[busIf.segAddr];
    assign busIf.segY = memY[busIf.segAddr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Model: each accepted check is a plan (start cycle, segments read, done cycle, cause).
    bit mActive = 1'b0;
    int mS = 0, mDone = 0, mLastK = 0, mHit = 0, mAddrHold = 0;
    bit mGo = 1'b0, mWall = 1'b0, mBody = 1'b0;
    bit eRd = 1'b0, eBusy = 1'b0, eDone = 1'b0;
    int eAddr = 0;

    function automatic int addrAt(input int n);
        if (mActive && mLastK > 0 && n >= mS + 2)
            return (n - mS - 1 < mLastK) ? (n - mS - 1) : mLastK;
        return mAddrHold;
    endfunction

    always @(posedge clk) begin
        int e, n, effLen;
        e = cyc;
        n = cyc + 1;
        if (reset) begin
            mActive = 1'b0; mGo = 1'b0; mWall = 1'b0; mBody = 1'b0; mAddrHold = 0;
        end else begin
            if ((!mActive || e > mDone) && busIf.start && !mGo) begin
                mAddrHold = addrAt(e);
                effLen  = (busIf.length == '0) ? 1 : int'(busIf.length);
                mS      = e;
                mActive = 1'b1;
                mHit    = 0;
                mLastK  = 0;
                if (busIf.walls && (int'(busIf.headX) < 143 || int'(busIf.headX) > 784 ||
                                    int'(busIf.headY) < 35  || int'(busIf.headY) > 514)) begin
                    mHit = 1;
                end else begin
                    for (int j = 1; j < effLen; j++) begin
                        mLastK = j;
                        if (memX[j] == busIf.headX && memY[j] == busIf.headY) begin
                            mHit = 2;
                            break;
                        end
                    end
                end
                mDone = mS + 2 + mLastK;
            end
            if (busIf.clearGame) begin
                mGo = 1'b0; mWall = 1'b0; mBody = 1'b0;
            end
            if (mActive && mDone == n && mHit != 0) begin
                mGo = 1'b1;
                if (mHit == 1) mWall = 1'b1;
                else           mBody = 1'b1;
            end
        end
        eBusy = mActive && n > mS && n < mDone;
        eDone = mActive && n == mDone;
        eRd   = mActive && mLastK > 0 && n >= mS + 2 && n <= mS + 1 + mLastK;
        eAddr = addrAt(n);
        cyc   = n;
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("segRd",    32'(busIf.segRd),    32'(eRd));
            chk("segAddr",  32'(busIf.segAddr),  32'(eAddr));
            chk("busy",     32'(busIf.busy),     32'(eBusy));
            chk("done",     32'(busIf.done),     32'(eDone));
            chk("gameOver", 32'(busIf.gameOver), 32'(mGo));
            chk("hitWall",  32'(busIf.hitWall),  32'(mWall));
            chk("hitBody",  32'(busIf.hitBody),  32'(mBody));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulseClear;
        busIf.clearGame = 1'b1;
        tick;
        busIf.clearGame = 1'b0;
    endtask

    task automatic runOne(input int x, input int y, input int len, input int w,
                          input int clrAt, input int extraAt,
                          output int lat, output int reads, output int maxAddr);
        busIf.headX  = COORD_W'(x);
        busIf.headY  = COORD_W'(y);
        busIf.length = LEN_W'(len);
        busIf.walls  = w[0];
        busIf.start  = 1'b1;
        lat = -1; reads = 0; maxAddr = 0;
        for (int i = 1; i <= 100; i++) begin
            tick;
            busIf.start     = (i == extraAt);
            busIf.clearGame = (i == clrAt);
            if (i == extraAt) busIf.headX = 20'd10;
            if (busIf.segRd) begin
                reads++;
                if (int'(busIf.segAddr) > maxAddr) maxAddr = int'(busIf.segAddr);
            end
            if (busIf.done) begin
                lat = i;
                break;
            end
        end
        busIf.start     = 1'b0;
        busIf.clearGame = 1'b0;
        tick;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, reads, maxA, cnt, len, hx, hy, k;
        bit ended;
        int bx [7] = '{143, 784, 143, 784, 785, 400, 400};
        int by [7] = '{35,  514, 514, 35,  200, 34,  515};
        int bw [7] = '{0,   0,   0,   0,   1,   1,   1};

        busIf.start = 1'b0; busIf.headX = '0; busIf.headY = '0; busIf.length = '0;
        busIf.walls = 1'b1; busIf.clearGame = 1'b0;
        for (int i = 0; i < 64; i++) begin
            memX[i] = COORD_W'(1000 + i);
            memY[i] = COORD_W'(7);
        end
        tick; tick; tick;
        reset = 1'b0;
        tick;
        chk("rst_segRd",    32'(busIf.segRd),    32'd0);
        chk("rst_segAddr",  32'(busIf.segAddr),  32'd0);
        chk("rst_busy",     32'(busIf.busy),     32'd0);
        chk("rst_gameOver", 32'(busIf.gameOver), 32'd0);

        // Wall hit: left of the playfield.
        runOne(142, 200, 5, 1, 0, 0, lat, reads, maxA);
        chk("t1_latency", 32'(lat), 32'd2);
        chk("t1_reads",   32'(reads), 32'd0);
        chk("t1_hitWall", 32'(busIf.hitWall), 32'd1);
        chk("t1_hitBody", 32'(busIf.hitBody), 32'd0);
        chk("t1_gameOver", 32'(busIf.gameOver), 32'd1);

        // Start while gameOver is set must be ignored.
        busIf.headX = 20'd400; busIf.headY = 20'd300; busIf.length = 6'd3; busIf.walls = 1'b0;
        busIf.start = 1'b1;
        tick;
        busIf.start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (busIf.busy || busIf.done) cnt++;
            tick;
        end
        chk("go_ignore", 32'(cnt), 32'd0);
        pulseClear;
        chk("clear_go", 32'(busIf.gameOver), 32'd0);

        // Walls off, no body match.
        runOne(142, 200, 4, 0, 0, 0, lat, reads, maxA);
        chk("t2_latency", 32'(lat), 32'd5);
        chk("t2_reads",   32'(reads), 32'd3);
        chk("t2_maxAddr", 32'(maxA), 32'd3);
        chk("t2_gameOver", 32'(busIf.gameOver), 32'd0);

        // Body hit on segment 3, with clearGame coinciding with the hit.
        memX[3] = 20'd300; memY[3] = 20'd240;
        runOne(300, 240, 6, 1, 4, 0, lat, reads, maxA);
        chk("t3_latency", 32'(lat), 32'd5);
        chk("t3_reads",   32'(reads), 32'd3);
        chk("t3_maxAddr", 32'(maxA), 32'd3);
        chk("t3_hitBody", 32'(busIf.hitBody), 32'd1);
        chk("t3_hitWall", 32'(busIf.hitWall), 32'd0);
        chk("t3_gameOver", 32'(busIf.gameOver), 32'd1);
        memX[3] = 20'd1003;
        pulseClear;

        // Bounds: corners legal, one past each edge is a wall.
        for (int i = 0; i < 7; i++) begin
            runOne(bx[i], by[i], 1, 1, 0, 0, lat, reads, maxA);
            chk("t4_latency", 32'(lat), 32'd2);
            chk("t4_hitWall", 32'(busIf.hitWall), 32'(bw[i]));
            pulseClear;
        end

        // Edge lengths.
        runOne(400, 300, 0, 1, 0, 0, lat, reads, maxA);
        chk("t5_len0_latency", 32'(lat), 32'd2);
        chk("t5_len0_reads",   32'(reads), 32'd0);
        runOne(400, 300, 1, 1, 0, 0, lat, reads, maxA);
        chk("t5_len1_latency", 32'(lat), 32'd2);
        chk("t5_len1_reads",   32'(reads), 32'd0);
        memX[62] = 20'd400; memY[62] = 20'd400;
        runOne(400, 400, 63, 1, 0, 0, lat, reads, maxA);
        chk("t5_len63_latency", 32'(lat), 32'd64);
        chk("t5_len63_maxAddr", 32'(maxA), 32'd62);
        chk("t5_len63_hitBody", 32'(busIf.hitBody), 32'd1);
        memX[62] = 20'd1062;
        pulseClear;
        runOne(400, 400, 63, 1, 0, 0, lat, reads, maxA);
        chk("t5_nohit_latency", 32'(lat), 32'd64);
        chk("t5_nohit_reads",   32'(reads), 32'd62);

        // Second start while busy is ignored.
        runOne(400, 300, 4, 1, 0, 2, lat, reads, maxA);
        chk("t6_busy_latency", 32'(lat), 32'd5);
        chk("t6_busy_gameOver", 32'(busIf.gameOver), 32'd0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (busIf.busy || busIf.done) cnt++;
            tick;
        end
        chk("t6_no_restart", 32'(cnt), 32'd0);

        // Reset in the middle of a scan.
        busIf.headX = 20'd500; busIf.headY = 20'd300; busIf.length = 6'd6; busIf.walls = 1'b0;
        busIf.start = 1'b1;
        tick;
        busIf.start = 1'b0;
        tick; tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("t6_rst_busy",    32'(busIf.busy),    32'd0);
        chk("t6_rst_segRd",   32'(busIf.segRd),   32'd0);
        chk("t6_rst_segAddr", 32'(busIf.segAddr), 32'd0);
        chk("t6_rst_done",    32'(busIf.done),    32'd0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (busIf.done) cnt++;
            tick;
        end
        chk("t6_rst_nodone", 32'(cnt), 32'd0);

        // Randomized traffic; every cycle is checked against the model.
        for (int it = 0; it < 250; it++) begin
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 10));
            hx  = ($urandom_range(0, 3) != 0) ? int'($urandom_range(143, 784)) : int'($urandom_range(100, 830));
            hy  = ($urandom_range(0, 3) != 0) ? int'($urandom_range(35, 514))  : int'($urandom_range(20, 530));
            for (int j = 0; j < 64; j++) begin
                memX[j] = COORD_W'($urandom_range(100, 830));
                memY[j] = COORD_W'($urandom_range(20, 530));
            end
            if (len > 1 && $urandom_range(0, 1) == 1) begin
                k = int'($urandom_range(1, len - 1));
                memX[k] = COORD_W'(hx);
                memY[k] = COORD_W'(hy);
            end
            if (busIf.gameOver && $urandom_range(0, 3) != 0) pulseClear;
            busIf.headX  = COORD_W'(hx);
            busIf.headY  = COORD_W'(hy);
            busIf.length = LEN_W'(len);
            busIf.walls  = 1'($urandom_range(0, 1));
            busIf.start  = 1'b1;
            ended = 1'b0;
            for (int i = 1; i <= 90; i++) begin
                tick;
                if (i >= 2 && !busIf.busy && !busIf.done) begin
                    busIf.start = 1'b0;
                    busIf.clearGame = 1'b0;
                    ended = 1'b1;
                    break;
                end
                busIf.start     = busIf.busy && ($urandom_range(0, 7) == 0);
                busIf.headX     = COORD_W'($urandom_range(0, 900));
                busIf.clearGame = ($urandom_range(0, 15) == 0);
                if (busIf.busy && $urandom_range(0, 200) == 0) begin
                    busIf.start = 1'b0;
                    busIf.clearGame = 1'b0;
                    reset = 1'b1;
                    tick;
                    reset = 1'b0;
                    tick;
                    ended = 1'b1;
                    break;
                end
            end
            busIf.start = 1'b0;
            busIf.clearGame = 1'b0;
            chk("rand_completes", 32'(ended), 32'd1);
        end

        tick; tick;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
